// File: rtl/alu_serial.sv
// alu_serial: slice-serial ALU. A WIDTH-bit operation is processed one
// SLICE-bit slice per clock, LSB slice first, through one shared slice
// datapath. The carry is held in a register between slices.
//
// Parameters: WIDTH (operand width), SLICE (bits per cycle); NS = WIDTH/SLICE.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start              request, sampled only while idle
//   A, B, Ai, Bi, Kin, M  operands, invert flags, carry-in and mode,
//                      all captured on an accepted start
//   busy               operation in progress
//   done               one-cycle pulse, result valid
//   Out, Kout          result register and carry out of the top slice
//   Zero, ZeroSlice    whole-word and per-slice zero flags from Out
// Optional: define ALU_SERIAL_OVF_EN to add the registered Ovf output
// (signed overflow in add mode, 0 in logic modes).
module alu_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4,
  localparam int NS = WIDTH / SLICE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ai,
  input  logic             Bi,
  input  logic             Kin,
  input  logic [1:0]       M,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Out,
  output logic             Kout,
  output logic             Zero,
  output logic [NS-1:0]    ZeroSlice
`ifdef ALU_SERIAL_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NS - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  // Operand registers shift right by one slice per RUN cycle so the
  // current slice is always at the bottom.
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       m_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic accept, last;
  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (cnt == LAST);

  // FSM
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slice datapath
  logic [SLICE-1:0] sa, sb, s_res;
  logic             s_cout, c;
`ifdef ALU_SERIAL_OVF_EN
  logic             c_msb, s_ovf;
`endif

  assign sa = a_q[SLICE-1:0];
  assign sb = b_q[SLICE-1:0];

  always_comb begin
    s_res  = '0;
    s_cout = 1'b0;
    c      = carry;
`ifdef ALU_SERIAL_OVF_EN
    c_msb  = 1'b0;
    s_ovf  = 1'b0;
`endif
    case (m_q)
      2'b00: begin
        for (int i = 0; i < SLICE; i++) begin
          s_res[i] = sa[i] ^ sb[i] ^ c;
`ifdef ALU_SERIAL_OVF_EN
          if (i == SLICE - 1) c_msb = c;
`endif
          c = (sa[i] & sb[i]) | (c & (sa[i] ^ sb[i]));
        end
        s_cout = c;
`ifdef ALU_SERIAL_OVF_EN
        s_ovf  = c_msb ^ c;
`endif
      end
      2'b01:   s_res = sa & sb;
      2'b10:   s_res = sa | sb;
      default: s_res = sa ^ sb;
    endcase
  end

  // Sequencing and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Out   <= '0;
      Kout  <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      Ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_q   <= A ^ {WIDTH{Ai}};
        b_q   <= B ^ {WIDTH{Bi}};
        m_q   <= M;
        carry <= Kin;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (state == RUN) begin
        for (int i = 0; i < NS; i++)
          if (cnt == CW'(i)) Out[i*SLICE +: SLICE] <= s_res;
        carry <= s_cout;
        cnt   <= cnt + CW'(1);
        a_q   <= a_q >> SLICE;
        b_q   <= b_q >> SLICE;
        if (last) begin
          Kout <= s_cout;
          busy <= 1'b0;
          done <= 1'b1;
`ifdef ALU_SERIAL_OVF_EN
          Ovf  <= s_ovf;
`endif
        end
      end
    end
  end

  // Flags straight from the result register
  assign Zero = ~|Out;
  for (genvar g = 0; g < NS; g++) begin : g_zs
    assign ZeroSlice[g] = ~|Out[g*SLICE +: SLICE];
  end

endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: self-checking bench for alu_serial. A cycle-level
// behavioural model (whole-word arithmetic plus a latency countdown) is
// compared against the DUT on every falling edge; directed scenarios add
// literal expectations.
module tb_alu_serial;
  localparam int W  = 16;
  localparam int S  = 4;
  localparam int NS = W / S;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic Ai = 1'b0, Bi = 1'b0, Kin = 1'b0;
  logic [1:0] M = 2'b00;
  logic busy, done, Kout, Zero;
  logic [W-1:0] Out;
  logic [NS-1:0] ZeroSlice;
`ifdef ALU_SERIAL_OVF_EN
  logic Ovf;
`endif

  alu_serial #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .Ai(Ai), .Bi(Bi),
    .Kin(Kin), .M(M), .busy(busy), .done(done), .Out(Out), .Kout(Kout),
    .Zero(Zero), .ZeroSlice(ZeroSlice)
`ifdef ALU_SERIAL_OVF_EN
    , .Ovf(Ovf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model
  logic         m_busy = 0, m_done = 0, m_k = 0, m_ovf = 0, p_k, p_ovf;
  logic [W-1:0] m_out = '0, p_out;
  int           m_rem = 0;

  task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ai,
                        input logic bi, input logic kin, input logic [1:0] m,
                        output logic [W-1:0] r, output logic k, output logic ov);
    logic [W-1:0] aa, bb;
    logic [W:0]   sum;
    aa = a ^ {W{ai}};
    bb = b ^ {W{bi}};
    sum = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, kin};
    k = 1'b0; ov = 1'b0;
    case (m)
      2'b00: begin
        r = sum[W-1:0]; k = sum[W];
        ov = (sum[W-1] ^ aa[W-1] ^ bb[W-1]) ^ sum[W];
      end
      2'b01: r = aa & bb;
      2'b10: r = aa | bb;
      default: r = aa ^ bb;
    endcase
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_busy = 0; m_done = 0; m_rem = 0; m_out = '0; m_k = 0; m_ovf = 0;
    end else if (m_busy) begin
      m_done = 0;
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0; m_done = 1; m_out = p_out; m_k = p_k; m_ovf = p_ovf;
      end
    end else begin
      m_done = 0;
      if (start) begin
        ref_op(A, B, Ai, Bi, Kin, M, p_out, p_k, p_ovf);
        m_busy = 1; m_rem = NS;
      end
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (cyc > 1) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (!m_busy) begin
        logic [NS-1:0] zs;
        for (int i = 0; i < NS; i++) zs[i] = (m_out[i*S +: S] == '0);
        chk("Out", Out, m_out);
        chk("Kout", Kout, m_k);
        chk("Zero", Zero, m_out == '0);
        chk("ZeroSlice", ZeroSlice, zs);
`ifdef ALU_SERIAL_OVF_EN
        chk("Ovf", Ovf, m_ovf);
`endif
      end
    end
  end

  // Stimulus helpers (called at a falling edge)
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ai,
                       input logic bi, input logic kin, input logic [1:0] m);
    A = a; B = b; Ai = ai; Bi = bi; Kin = kin; M = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int t);
    t = -1;
    for (int i = 0; i < 30; i++) begin
      if (done) begin t = cyc; return; end
      @(negedge clk);
    end
    chk({name, "_timeout"}, 1'b0, 1'b1);
  endtask

  int t0, t1, t2, t3, ndone;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out", Out, 16'h0000);
    chk("rst_kout", Kout, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // 0x00FF + 0x0001
    t0 = cyc;
    issue(16'h00FF, 16'h0001, 0, 0, 0, 2'b00);
    wait_done("add", t1);
    chk("add_latency", t1 - t0, NS + 1);
    chk("add_out", Out, 16'h0100);
    chk("add_kout", Kout, 1'b0);
    chk("add_zero", Zero, 1'b0);
    chk("add_zs", ZeroSlice, 4'b1011);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);

    // subtract equal values
    issue(16'h1234, 16'h1234, 0, 1, 1, 2'b00);
    wait_done("sub", t1);
    chk("sub_out", Out, 16'h0000);
    chk("sub_kout", Kout, 1'b1);
    chk("sub_zero", Zero, 1'b1);
    chk("sub_zs", ZeroSlice, 4'b1111);
    @(negedge clk);
    chk("hold_out", Out, 16'h0000);

    // back-to-back logic ops, next start given in the done cycle
    issue(16'hF0F0, 16'hFF00, 0, 0, 1, 2'b01);
    wait_done("and", t1);
    chk("and_out", Out, 16'hF000);
    chk("and_kout", Kout, 1'b0);
    issue(16'hF0F0, 16'hFF00, 0, 0, 1, 2'b10);
    wait_done("or", t2);
    chk("or_out", Out, 16'hFFF0);
    chk("or_kout", Kout, 1'b0);
    chk("b2b_gap1", t2 - t1, NS + 1);
    issue(16'hF0F0, 16'hFF00, 0, 0, 1, 2'b11);
    wait_done("xor", t3);
    chk("xor_out", Out, 16'h0FF0);
    chk("xor_kout", Kout, 1'b0);
    chk("b2b_gap2", t3 - t2, NS + 1);
    @(negedge clk);

    // start held during RUN with changing operands
    A = 16'h0003; B = 16'h0004; Ai = 0; Bi = 0; Kin = 0; M = 2'b00; start = 1'b1;
    for (int i = 0; i < NS - 1; i++) begin
      @(negedge clk);
      A = 16'($urandom);
    end
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        ndone++;
        chk("held_out", Out, 16'h0007);
      end
      @(negedge clk);
    end
    chk("held_ndone", ndone, 1);

    // reset in the second RUN cycle
    issue(16'h1111, 16'h2222, 0, 0, 0, 2'b00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_out", Out, 16'h0000);
    chk("abort_kout", Kout, 1'b0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort_ndone", ndone, 0);

`ifdef ALU_SERIAL_OVF_EN
    issue(16'h7FFF, 16'h0001, 0, 0, 0, 2'b00);
    wait_done("ovf1", t1);
    chk("ovf1_out", Out, 16'h8000);
    chk("ovf1_ovf", Ovf, 1'b1);
    chk("ovf1_kout", Kout, 1'b0);
    issue(16'hFFFF, 16'h0001, 0, 0, 0, 2'b00);
    wait_done("ovf2", t1);
    chk("ovf2_out", Out, 16'h0000);
    chk("ovf2_ovf", Ovf, 1'b0);
    chk("ovf2_kout", Kout, 1'b1);
`endif

    // randomized traffic, including starts while busy and rare resets
    for (int i = 0; i < 600; i++) begin
      A = 16'($urandom); B = 16'($urandom);
      if ($urandom_range(0, 7) == 0) A = B;
      Ai = 1'($urandom); Bi = 1'($urandom); Kin = 1'($urandom);
      M = 2'($urandom);
      start = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    start = 1'b0; reset = 1'b0;
    repeat (NS + 3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
